// File: rtl/fp_add_sequencer_if.sv
// Handshake and result bundle between a host and the single-precision FP add sequencer.
// The host drives operands and the consumer ready; the sequencer returns the result and flags.
interface fp_add_sequencer_if;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic        inValid;
    logic        inReady;
    logic [31:0] result;
    logic        outValid;
    logic        outReady;
    logic        overflow;
    logic        invalid;
    logic        busy;

    modport master (
        output operandA, operandB, inValid, outReady,
        input  inReady, result, outValid, overflow, invalid, busy
    );

    modport slave (
        input  operandA, operandB, inValid, outReady,
        output inReady, result, outValid, overflow, invalid, busy
    );
endinterface

// File: rtl/fp_add_sequencer.sv
// Multi-cycle binary32 adder sequencer: align, add, normalize (one bit per cycle), round-to-nearest-even.
// One transaction in flight; result and flags are registered and held until the consumer accepts them.
module fp_add_sequencer #(
    parameter logic [31:0] NAN_VALUE       = 32'h7FC0_0000,
    parameter bit          FLUSH_SUBNORMAL = 1'b0
) (
    input logic               clock,
    input logic               reset,
    fp_add_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        ROUND = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Right-shift a 24-bit significand into a {mant, G, R, S} field, collapsing shifted-out bits into S.
    function automatic logic [26:0] align_shift(input logic [23:0] sig, input logic [7:0] shamt);
        logic [49:0] ext;
        logic [49:0] shifted;
        if (shamt > 8'd26) begin
            align_shift = {26'd0, |sig};
        end else begin
            ext         = {sig, 26'd0};
            shifted     = ext >> shamt;
            align_shift = {shifted[49:24], |shifted[23:0]};
        end
    endfunction

    function automatic logic [31:0] pack_inf(input logic sgn);
        pack_inf = {sgn, 8'hFF, 23'd0};
    endfunction

    state_t      state_r;
    state_t      state_next;

    logic [31:0] op_a_r;
    logic [31:0] op_b_r;
    logic [26:0] mant_big_r;
    logic [26:0] mant_small_r;
    logic        sign_big_r;
    logic        sign_small_r;
    logic [7:0]  exp_r;
    logic        sign_r;
    logic [27:0] work_r;

    logic [31:0] op_a_next;
    logic [31:0] op_b_next;
    logic [26:0] mant_big_next;
    logic [26:0] mant_small_next;
    logic        sign_big_next;
    logic        sign_small_next;
    logic [7:0]  exp_next;
    logic        sign_next;
    logic [27:0] work_next;

    logic [31:0] result_r;
    logic        overflow_r;
    logic        invalid_r;
    logic        out_valid_r;
    logic        in_ready_r;
    logic        busy_r;

    logic        load_done_s;
    logic [31:0] done_result_s;
    logic        done_ovf_s;
    logic        done_inv_s;
    logic        handshake_s;

    logic [7:0]  exp_a_s;
    logic [7:0]  exp_b_s;
    logic        sign_a_s;
    logic        sign_b_s;
    logic        nan_a_s;
    logic        nan_b_s;
    logic        inf_a_s;
    logic        inf_b_s;
    logic [23:0] sig_a_s;
    logic [23:0] sig_b_s;
    logic [7:0]  eff_exp_a_s;
    logic [7:0]  eff_exp_b_s;
    logic        round_inc_s;
    logic [24:0] rounded_s;

    assign exp_a_s  = op_a_r[30:23];
    assign exp_b_s  = op_b_r[30:23];
    assign sign_a_s = op_a_r[31];
    assign sign_b_s = op_b_r[31];
    assign nan_a_s  = (exp_a_s == 8'hFF) && (op_a_r[22:0] != 23'd0);
    assign nan_b_s  = (exp_b_s == 8'hFF) && (op_b_r[22:0] != 23'd0);
    assign inf_a_s  = (exp_a_s == 8'hFF) && (op_a_r[22:0] == 23'd0);
    assign inf_b_s  = (exp_b_s == 8'hFF) && (op_b_r[22:0] == 23'd0);

    // Exponent-0 operands carry no hidden bit and sit at effective exponent 1 (or become zero when flushing).
    assign sig_a_s     = (FLUSH_SUBNORMAL && (exp_a_s == 8'd0)) ? 24'd0 : {(exp_a_s != 8'd0), op_a_r[22:0]};
    assign sig_b_s     = (FLUSH_SUBNORMAL && (exp_b_s == 8'd0)) ? 24'd0 : {(exp_b_s != 8'd0), op_b_r[22:0]};
    assign eff_exp_a_s = (exp_a_s == 8'd0) ? 8'd1 : exp_a_s;
    assign eff_exp_b_s = (exp_b_s == 8'd0) ? 8'd1 : exp_b_s;

    // work_r layout: [27] carry, [26] leading bit, [25:3] fraction, [2] G, [1] R, [0] S.
    assign round_inc_s = work_r[2] & (work_r[1] | work_r[0] | work_r[3]);
    assign rounded_s   = {1'b0, work_r[26:3]} + {24'd0, round_inc_s};

    assign handshake_s = (state_r == DONE) && out_valid_r && bus.outReady;

    // Next-state and datapath next values for every sequencing state.
    always_comb begin
        state_next      = state_r;
        op_a_next       = op_a_r;
        op_b_next       = op_b_r;
        mant_big_next   = mant_big_r;
        mant_small_next = mant_small_r;
        sign_big_next   = sign_big_r;
        sign_small_next = sign_small_r;
        exp_next        = exp_r;
        sign_next       = sign_r;
        work_next       = work_r;
        load_done_s     = 1'b0;
        done_result_s   = 32'h0000_0000;
        done_ovf_s      = 1'b0;
        done_inv_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.inValid && in_ready_r) begin
                    op_a_next  = bus.operandA;
                    op_b_next  = bus.operandB;
                    state_next = ALIGN;
                end else begin
                    state_next = IDLE;
                end
            end
            ALIGN: begin
                if ((exp_a_s == 8'hFF) || (exp_b_s == 8'hFF)) begin
                    load_done_s = 1'b1;
                    state_next  = DONE;
                    if (nan_a_s || nan_b_s || (inf_a_s && inf_b_s && (sign_a_s != sign_b_s))) begin
                        done_result_s = NAN_VALUE;
                        done_inv_s    = 1'b1;
                    end else if (inf_a_s) begin
                        done_result_s = pack_inf(sign_a_s);
                    end else begin
                        done_result_s = pack_inf(sign_b_s);
                    end
                end else if (eff_exp_a_s >= eff_exp_b_s) begin
                    mant_big_next   = {sig_a_s, 3'b000};
                    mant_small_next = align_shift(sig_b_s, eff_exp_a_s - eff_exp_b_s);
                    sign_big_next   = sign_a_s;
                    sign_small_next = sign_b_s;
                    exp_next        = eff_exp_a_s;
                    state_next      = ADD;
                end else begin
                    mant_big_next   = {sig_b_s, 3'b000};
                    mant_small_next = align_shift(sig_a_s, eff_exp_b_s - eff_exp_a_s);
                    sign_big_next   = sign_b_s;
                    sign_small_next = sign_a_s;
                    exp_next        = eff_exp_b_s;
                    state_next      = ADD;
                end
            end
            ADD: begin
                if (sign_big_r == sign_small_r) begin
                    work_next  = {1'b0, mant_big_r} + {1'b0, mant_small_r};
                    sign_next  = sign_a_s;
                    state_next = NORM;
                end else if (mant_big_r > mant_small_r) begin
                    work_next  = {1'b0, mant_big_r - mant_small_r};
                    sign_next  = sign_big_r;
                    state_next = NORM;
                end else if (mant_big_r < mant_small_r) begin
                    work_next  = {1'b0, mant_small_r - mant_big_r};
                    sign_next  = sign_small_r;
                    state_next = NORM;
                end else begin
                    load_done_s   = 1'b1;
                    done_result_s = 32'h0000_0000;
                    state_next    = DONE;
                end
            end
            NORM: begin
                if (work_r[27]) begin
                    if (exp_r == 8'd254) begin
                        load_done_s   = 1'b1;
                        done_result_s = pack_inf(sign_r);
                        done_ovf_s    = 1'b1;
                        state_next    = DONE;
                    end else begin
                        work_next  = {1'b0, work_r[27:2], work_r[1] | work_r[0]};
                        exp_next   = exp_r + 8'd1;
                        state_next = ROUND;
                    end
                end else if (!work_r[26] && (exp_r > 8'd1)) begin
                    work_next  = {work_r[26:0], 1'b0};
                    exp_next   = exp_r - 8'd1;
                    state_next = NORM;
                end else begin
                    state_next = ROUND;
                end
            end
            ROUND: begin
                load_done_s = 1'b1;
                state_next  = DONE;
                if (rounded_s[24]) begin
                    if (exp_r == 8'd254) begin
                        done_result_s = pack_inf(sign_r);
                        done_ovf_s    = 1'b1;
                    end else begin
                        done_result_s = {sign_r, exp_r + 8'd1, 23'd0};
                    end
                end else if (!rounded_s[23]) begin
                    // Leading bit still clear here means a subnormal result, encoded with exponent 0.
                    if (FLUSH_SUBNORMAL) begin
                        done_result_s = {sign_r, 31'd0};
                    end else begin
                        done_result_s = {sign_r, 8'd0, rounded_s[22:0]};
                    end
                end else begin
                    done_result_s = {sign_r, exp_r, rounded_s[22:0]};
                end
            end
            DONE: begin
                if (handshake_s) begin
                    state_next = IDLE;
                end else begin
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Operand and stage registers carried between sequencing states.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_a_r       <= 32'd0;
            op_b_r       <= 32'd0;
            mant_big_r   <= 27'd0;
            mant_small_r <= 27'd0;
            sign_big_r   <= 1'b0;
            sign_small_r <= 1'b0;
            exp_r        <= 8'd0;
            sign_r       <= 1'b0;
            work_r       <= 28'd0;
        end else begin
            op_a_r       <= op_a_next;
            op_b_r       <= op_b_next;
            mant_big_r   <= mant_big_next;
            mant_small_r <= mant_small_next;
            sign_big_r   <= sign_big_next;
            sign_small_r <= sign_small_next;
            exp_r        <= exp_next;
            sign_r       <= sign_next;
            work_r       <= work_next;
        end
    end

    // Registered outputs; outValid rises the cycle after DONE is entered and drops after the accept.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result_r    <= 32'd0;
            overflow_r  <= 1'b0;
            invalid_r   <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r  <= (state_next == IDLE);
            busy_r      <= (state_next != IDLE);
            out_valid_r <= (state_r == DONE) && !handshake_s;
            if (load_done_s) begin
                result_r   <= done_result_s;
                overflow_r <= done_ovf_s;
                invalid_r  <= done_inv_s;
            end else if (handshake_s) begin
                overflow_r <= 1'b0;
                invalid_r  <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
                invalid_r  <= invalid_r;
            end
        end
    end

    assign bus.inReady  = in_ready_r;
    assign bus.result   = result_r;
    assign bus.outValid = out_valid_r;
    assign bus.overflow = overflow_r;
    assign bus.invalid  = invalid_r;
    assign bus.busy     = busy_r;

endmodule
